// File: rtl/regfile_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared types and defaults for the multi-port register file.
// Revision: 1.0 - initial multi-port release
// ============================================================================
package regfile_pkg;

    localparam int c_DEF_DATA_W = 32;
    localparam int c_DEF_ADDR_W = 5;

    // Clear sequencer states
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // Number of entries addressed by an address of the given width
    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_clear_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rf_clear_seq
// Brief   : Post-reset clear sequencer. Walks every entry once writing zero,
//           then raises ready. Any reset restarts the walk from entry 0.
// Revision: 1.0 - initial multi-port release
// ============================================================================
module rf_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int              c_DEPTH = rf_depth(ADDR_W);
    // Counter is one bit wider than the address so it can reach DEPTH
    localparam logic [ADDR_W:0] c_LAST  = (ADDR_W+1)'(c_DEPTH - 1);
    localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);

    rf_state_e         r_state;
    logic [ADDR_W:0]   r_clr_cnt;
    logic              r_ready;

    // Sequencer FSM: CLEAR walks the entries, RUN holds ready high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RF_CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + c_ONE;
                    if (r_clr_cnt == c_LAST) begin
                        r_state <= RF_RUN;
                        r_ready <= 1'b1;
                    end
                end
                RF_RUN: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign clr_we   = (r_state == RF_CLEAR);
    assign clr_addr = r_clr_cnt[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Brief   : Parametrised multi-port register file with post-reset clear,
//           ready flag, optional hardwired zero entry and optional
//           write-first bypass to the combinational read ports.
// Revision: 1.0 - initial multi-port release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int ADDR_W   = c_DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ready,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wa,
    input  logic [NUM_WR*DATA_W-1:0] wd
);

    localparam int c_DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_ready;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [NUM_WR-1:0] w_wr_en;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .reset    (reset),
        .ready    (w_ready),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign ready = w_ready;

    // Effective per-port write enable: only when usable, and never to a hardwired zero entry
    generate
        for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_en
            logic w_zero_hit;
            assign w_zero_hit = (ZERO_REG != 0) && (wa[j*ADDR_W +: ADDR_W] == '0);
            assign w_wr_en[j] = w_ready && we[j] && !w_zero_hit;
        end
    endgenerate

    // Storage update: clear writes take precedence; among user ports the last (highest) wins
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_en[j]) begin
                    r_mem[wa[j*ADDR_W +: ADDR_W]] <= wd[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Per-read-port mux: array read, optional bypass, zero entry and not-ready forcing
    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_val;

            assign w_ra = ra[i*ADDR_W +: ADDR_W];

            // Write-first forwarding scans ports in ascending order so the highest match wins
            always_comb begin
                w_val = r_mem[w_ra];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (w_wr_en[j] && (wa[j*ADDR_W +: ADDR_W] == w_ra)) begin
                            w_val = wd[j*DATA_W +: DATA_W];
                        end
                    end
                end
                if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    w_val = '0;
                end
                if (!w_ready) begin
                    w_val = '0;
                end
            end

            assign rd[i*DATA_W +: DATA_W] = w_val;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_regfile_mp
// Brief   : Self-checking bench for regfile_mp. Instance A: 2R/2W, bypass,
//           zero entry. Instance B: 2R/1W, no bypass, entry 0 writable.
// Revision: 1.0 - initial multi-port release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    // Instance A signals
    logic        ready_a;
    logic [9:0]  ra_a = '0;
    logic [63:0] rd_a;
    logic [1:0]  we_a = '0;
    logic [9:0]  wa_a = '0;
    logic [63:0] wd_a = '0;

    // Instance B signals
    logic        ready_b;
    logic [9:0]  ra_b = '0;
    logic [63:0] rd_b;
    logic [0:0]  we_b = '0;
    logic [4:0]  wa_b = '0;
    logic [31:0] wd_b = '0;

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .ready(ready_a),
        .ra(ra_a), .rd(rd_a), .we(we_a), .wa(wa_a), .wd(wd_a)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(0), .BYPASS(0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .ready(ready_b),
        .ra(ra_b), .rd(rd_b), .we(we_b), .wa(wa_b), .wd(wd_b)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] eb1;
    } vec_t;

    vec_t vecs [12];
    vec_t sb_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(
        input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [31:0] ea0, input logic [31:0] ea1,
        input logic [31:0] eb0, input logic [31:0] eb1);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1;
        v.ea0 = ea0; v.ea1 = ea1; v.eb0 = eb0; v.eb1 = eb1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        we_a = v.we;
        wa_a = {v.wa1, v.wa0};
        wd_a = {v.wd1, v.wd0};
        ra_a = {v.ra1, v.ra0};
        we_b = v.we[0:0];
        wa_b = v.wa0;
        wd_b = v.wd0;
        ra_b = {v.ra1, v.ra0};
    endtask

    // Drive one vector after a rising edge, compare combinational reads at the falling edge
    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        @(posedge clk);
        #1;
        drive(v);
        sb_q.push_back(v);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, "_a_rd0"}, rd_a[31:0],  e.ea0);
        chk({tag, "_a_rd1"}, rd_a[63:32], e.ea1);
        chk({tag, "_b_rd0"}, rd_b[31:0],  e.eb0);
        chk({tag, "_b_rd1"}, rd_b[63:32], e.eb1);
    endtask

    // One-cycle reset pulse; ready and reads must be zero right after it is sampled
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready_a", {31'd0, ready_a}, 32'd0);
        chk("rst_ready_b", {31'd0, ready_b}, 32'd0);
        chk("rst_rd_a", rd_a[31:0], 32'd0);
        chk("rst_rd_b", rd_b[31:0], 32'd0);
        reset = 1'b0;
    endtask

    // Ready must stay low for 31 edges after reset release and rise on the 32nd
    task automatic check_clear(input string tag);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            if (k == 32) begin
                #1;
                we_a = '0;
                we_b = '0;
            end
            @(negedge clk);
            chk({tag, "_ready_a"}, {31'd0, ready_a}, (k == 32) ? 32'd1 : 32'd0);
            chk({tag, "_ready_b"}, {31'd0, ready_b}, (k == 32) ? 32'd1 : 32'd0);
            if (k < 32) begin
                chk({tag, "_rd_a"}, rd_a[31:0], 32'd0);
                chk({tag, "_rd_b"}, rd_b[63:32], 32'd0);
            end
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            run_vec(mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'(a), 5'(31 - a),
                       32'd0, 32'd0, 32'd0, 32'd0), tag);
        end
    endtask

    initial begin
        // Register-file scenario table; expectations derived from the spec behaviour
        vecs[0]  = mk(2'b01, 5'd5,  32'hDEADBEEF, 5'd0, 32'd0,        5'd5,  5'd5,
                      32'hDEADBEEF, 32'hDEADBEEF, 32'd0,        32'd0);
        vecs[1]  = mk(2'b00, 5'd0,  32'd0,        5'd0, 32'd0,        5'd5,  5'd0,
                      32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'd0);
        vecs[2]  = mk(2'b01, 5'd0,  32'h12345678, 5'd0, 32'd0,        5'd0,  5'd5,
                      32'd0,        32'hDEADBEEF, 32'd0,        32'hDEADBEEF);
        vecs[3]  = mk(2'b00, 5'd0,  32'd0,        5'd0, 32'd0,        5'd0,  5'd0,
                      32'd0,        32'd0,        32'h12345678, 32'h12345678);
        vecs[4]  = mk(2'b11, 5'd9,  32'h00001111, 5'd9, 32'h00002222, 5'd9,  5'd9,
                      32'h00002222, 32'h00002222, 32'd0,        32'd0);
        vecs[5]  = mk(2'b00, 5'd0,  32'd0,        5'd0, 32'd0,        5'd9,  5'd5,
                      32'h00002222, 32'hDEADBEEF, 32'h00001111, 32'hDEADBEEF);
        vecs[6]  = mk(2'b11, 5'd7,  32'hAAAA0007, 5'd8, 32'hBBBB0008, 5'd7,  5'd8,
                      32'hAAAA0007, 32'hBBBB0008, 32'd0,        32'd0);
        vecs[7]  = mk(2'b00, 5'd0,  32'd0,        5'd0, 32'd0,        5'd8,  5'd7,
                      32'hBBBB0008, 32'hAAAA0007, 32'd0,        32'hAAAA0007);
        vecs[8]  = mk(2'b10, 5'd5,  32'h55555555, 5'd31, 32'hCAFEF00D, 5'd31, 5'd5,
                      32'hCAFEF00D, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF);
        vecs[9]  = mk(2'b00, 5'd0,  32'd0,        5'd0, 32'd0,        5'd31, 5'd9,
                      32'hCAFEF00D, 32'h00002222, 32'd0,        32'h00001111);
        vecs[10] = mk(2'b11, 5'd31, 32'h01010101, 5'd5, 32'h02020202, 5'd5,  5'd31,
                      32'h02020202, 32'h01010101, 32'hDEADBEEF, 32'd0);
        vecs[11] = mk(2'b00, 5'd0,  32'd0,        5'd0, 32'd0,        5'd5,  5'd31,
                      32'h02020202, 32'h01010101, 32'hDEADBEEF, 32'h01010101);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init_ready_a", {31'd0, ready_a}, 32'd0);
        chk("init_ready_b", {31'd0, ready_b}, 32'd0);

        // Writes attempted throughout CLEAR must be ignored
        we_a = 2'b11;
        wa_a = {5'd3, 5'd31};
        wd_a = {32'h0000FFFF, 32'h0000FFFF};
        ra_a = {5'd3, 5'd31};
        we_b = 1'b1;
        wa_b = 5'd31;
        wd_b = 32'h0000FFFF;
        ra_b = {5'd31, 5'd3};
        reset = 1'b0;
        check_clear("clr1");
        read_all_zero("zero1");

        // Functional table
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset from RUN with filled entries, then reset again partway through CLEAR
        do_reset();
        repeat (10) @(posedge clk);
        do_reset();
        check_clear("clr2");
        read_all_zero("zero2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
